// File: rtl/mc_proc_pkg.sv
// Shared definitions for the multi-cycle processor controller: opcodes,
// FSM states, instruction classes and mux-select encodings.
package mc_proc_pkg;

  localparam logic [3:0] OP_ALU_R  = 4'b0000;
  localparam logic [3:0] OP_ALU_I  = 4'b1000;
  localparam logic [3:0] OP_LW     = 4'b1001;
  localparam logic [3:0] OP_SW     = 4'b0101;
  localparam logic [3:0] OP_CMP_R  = 4'b0010;
  localparam logic [3:0] OP_CMP_I  = 4'b1010;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_JAL    = 4'b1011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU_R   = 4'd0,
    CL_ALU_I   = 4'd1,
    CL_LW      = 4'd2,
    CL_SW      = 4'd3,
    CL_CMP_R   = 4'd4,
    CL_CMP_I   = 4'd5,
    CL_BRANCH  = 4'd6,
    CL_JAL     = 4'd7,
    CL_ILLEGAL = 4'd8
  } opclass_t;

  // PC source select
  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;

  // Register-file write data select
  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;

  // Compare-type classes drive the ALU into compare mode.
  function automatic logic is_cmp(input opclass_t cls);
    return (cls == CL_CMP_R) || (cls == CL_CMP_I) || (cls == CL_BRANCH);
  endfunction

endpackage

// File: rtl/mc_proc_decode.sv
// Combinational instruction decode: opcode class, ALU function and
// register-file indices straight from the instruction word.
module mc_proc_decode
  import mc_proc_pkg::*;
(
  input  logic [31:0] iword,
  output opclass_t    op_class,
  output logic [4:0]  alu_fn,
  output logic [3:0]  rd_index0,
  output logic [3:0]  rd_index1,
  output logic [3:0]  wrt_index
);

  // Map the 4-bit opcode onto an instruction class; unknown opcodes are illegal.
  always_comb begin
    op_class = CL_ILLEGAL;
    case (iword[3:0])
      OP_ALU_R:  op_class = CL_ALU_R;
      OP_ALU_I:  op_class = CL_ALU_I;
      OP_LW:     op_class = CL_LW;
      OP_SW:     op_class = CL_SW;
      OP_CMP_R:  op_class = CL_CMP_R;
      OP_CMP_I:  op_class = CL_CMP_I;
      OP_BRANCH: op_class = CL_BRANCH;
      OP_JAL:    op_class = CL_JAL;
      default:   op_class = CL_ILLEGAL;
    endcase
  end

  // SW and BRANCH read two sources and write none, so their read ports take
  // the top two register fields instead of rs1/rs2.
  always_comb begin
    rd_index0 = iword[27:24];
    rd_index1 = iword[23:20];
    if ((op_class == CL_SW) || (op_class == CL_BRANCH)) begin
      rd_index0 = iword[31:28];
      rd_index1 = iword[27:24];
    end else begin
      rd_index0 = iword[27:24];
      rd_index1 = iword[23:20];
    end
  end

  assign wrt_index = iword[31:28];
  assign alu_fn    = {is_cmp(op_class), iword[7:4]};

endmodule

// File: rtl/mc_proc_controller.sv
// Multi-cycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Memory-side controls are registered; strobes that depend on memReady or
// aluCompTrue in the same cycle are decoded from the registered state.
module mc_proc_controller
  import mc_proc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iword,
  input  logic        aluCompTrue,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWrtEn,
  output logic        memAddrSel,
  output logic        irWrtEn,
  output logic        pcWrtEn,
  output logic [1:0]  pcSel,
  output logic [4:0]  aluFn,
  output logic        aluSrc2Sel,
  output logic [3:0]  rdIndex0,
  output logic [3:0]  rdIndex1,
  output logic [3:0]  wrtIndex,
  output logic        regFileWrtEn,
  output logic [1:0]  regFileWrtSel,
  output logic        illegal
);

  state_t   state_r;
  logic     mem_req_r;
  logic     mem_wrt_en_r;
  logic     mem_addr_sel_r;
  logic     illegal_r;
  opclass_t op_class_s;
  logic     mem_done_s;

  mc_proc_decode u_decode (
    .iword     (iword),
    .op_class  (op_class_s),
    .alu_fn    (aluFn),
    .rd_index0 (rdIndex0),
    .rd_index1 (rdIndex1),
    .wrt_index (wrtIndex)
  );

  // memReady only counts while a request is actually outstanding.
  assign mem_done_s = mem_req_r & memReady;

  // State register plus registered memory controls, loaded for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_FETCH;
      mem_req_r      <= 1'b0;
      mem_wrt_en_r   <= 1'b0;
      mem_addr_sel_r <= 1'b0;
      illegal_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // The first cycle after reset raises the request; later entries arrive with it set.
          mem_req_r      <= ~mem_done_s;
          mem_wrt_en_r   <= 1'b0;
          mem_addr_sel_r <= 1'b0;
          state_r        <= mem_done_s ? ST_DECODE : ST_FETCH;
        end
        ST_DECODE: begin
          if (op_class_s == CL_ILLEGAL) begin
            state_r   <= ST_HALT;
            illegal_r <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_class_s)
            CL_ALU_R, CL_ALU_I, CL_CMP_R, CL_CMP_I: state_r <= ST_WB;
            CL_LW, CL_SW: begin
              state_r        <= ST_MEM;
              mem_req_r      <= 1'b1;
              mem_addr_sel_r <= 1'b1;
              mem_wrt_en_r   <= (op_class_s == CL_SW);
            end
            CL_BRANCH, CL_JAL: begin
              state_r        <= ST_FETCH;
              mem_req_r      <= 1'b1;
              mem_addr_sel_r <= 1'b0;
              mem_wrt_en_r   <= 1'b0;
            end
            default: begin
              state_r   <= ST_HALT;
              illegal_r <= 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          // Controls stay frozen until the access completes, then next fetch is requested.
          if (mem_done_s) begin
            state_r        <= ST_FETCH;
            mem_req_r      <= 1'b1;
            mem_addr_sel_r <= 1'b0;
            mem_wrt_en_r   <= 1'b0;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB: begin
          state_r        <= ST_FETCH;
          mem_req_r      <= 1'b1;
          mem_addr_sel_r <= 1'b0;
          mem_wrt_en_r   <= 1'b0;
        end
        ST_HALT: begin
          state_r        <= ST_HALT;
          mem_req_r      <= 1'b0;
          mem_addr_sel_r <= 1'b0;
          mem_wrt_en_r   <= 1'b0;
          illegal_r      <= 1'b1;
        end
        default: begin
          state_r        <= ST_HALT;
          mem_req_r      <= 1'b0;
          mem_addr_sel_r <= 1'b0;
          mem_wrt_en_r   <= 1'b0;
          illegal_r      <= 1'b1;
        end
      endcase
    end
  end

  // Same-cycle strobes and selects decoded from the current state and live inputs.
  always_comb begin
    irWrtEn       = 1'b0;
    pcWrtEn       = 1'b0;
    pcSel         = PCSEL_PC4;
    aluSrc2Sel    = 1'b0;
    regFileWrtEn  = 1'b0;
    regFileWrtSel = WSEL_ALU;
    case (state_r)
      ST_FETCH: begin
        irWrtEn = mem_done_s;
        pcWrtEn = mem_done_s;
        pcSel   = PCSEL_PC4;
      end
      ST_EXEC: begin
        aluSrc2Sel = (op_class_s != CL_ALU_R) && (op_class_s != CL_CMP_R);
        case (op_class_s)
          CL_BRANCH: begin
            pcWrtEn = aluCompTrue;
            pcSel   = PCSEL_BR;
          end
          CL_JAL: begin
            pcWrtEn       = 1'b1;
            pcSel         = PCSEL_ALU;
            regFileWrtEn  = 1'b1;
            regFileWrtSel = WSEL_PC4;
          end
          default: begin
            pcWrtEn = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        aluSrc2Sel = 1'b1;
        if (op_class_s == CL_LW) begin
          regFileWrtEn  = mem_done_s;
          regFileWrtSel = WSEL_MEM;
        end else begin
          regFileWrtEn  = 1'b0;
        end
      end
      ST_WB: begin
        regFileWrtEn  = 1'b1;
        regFileWrtSel = WSEL_ALU;
      end
      default: begin
        irWrtEn = 1'b0;
      end
    endcase
  end

  assign memReq     = mem_req_r;
  assign memWrtEn   = mem_wrt_en_r;
  assign memAddrSel = mem_addr_sel_r;
  assign illegal    = illegal_r;

endmodule

// File: tb/tb_mc_proc_controller.sv
// Directed testbench for mc_proc_controller: walks each instruction class
// cycle by cycle and compares strobes/selects against hand-derived values.
module tb_mc_proc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iword;
  logic        aluCompTrue;
  logic        memReady;
  logic        memReq, memWrtEn, memAddrSel, irWrtEn, pcWrtEn;
  logic [1:0]  pcSel;
  logic [4:0]  aluFn;
  logic        aluSrc2Sel;
  logic [3:0]  rdIndex0, rdIndex1, wrtIndex;
  logic        regFileWrtEn;
  logic [1:0]  regFileWrtSel;
  logic        illegal;
  logic [5:0]  strb;

  int tests  = 0;
  int failed = 0;

  mc_proc_controller dut (
    .clk           (clk),
    .reset         (reset),
    .iword         (iword),
    .aluCompTrue   (aluCompTrue),
    .memReady      (memReady),
    .memReq        (memReq),
    .memWrtEn      (memWrtEn),
    .memAddrSel    (memAddrSel),
    .irWrtEn       (irWrtEn),
    .pcWrtEn       (pcWrtEn),
    .pcSel         (pcSel),
    .aluFn         (aluFn),
    .aluSrc2Sel    (aluSrc2Sel),
    .rdIndex0      (rdIndex0),
    .rdIndex1      (rdIndex1),
    .wrtIndex      (wrtIndex),
    .regFileWrtEn  (regFileWrtEn),
    .regFileWrtSel (regFileWrtSel),
    .illegal       (illegal)
  );

  // strobe vector: {memReq, memAddrSel, memWrtEn, irWrtEn, pcWrtEn, regFileWrtEn}
  assign strb = {memReq, memAddrSel, memWrtEn, irWrtEn, pcWrtEn, regFileWrtEn};

  always #5 clk = ~clk;

  // Advance to the next cycle: drive inputs at the falling edge, settle, then sample.
  task automatic cyc(input logic rdy, input logic cmp);
    @(negedge clk);
    memReady    = rdy;
    aluCompTrue = cmp;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; memReady = 1'b1; aluCompTrue = 1'b1; iword = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({strb, illegal} !== 7'b0) begin
      $display("FAIL reset_state: got %b required %b", {strb, illegal}, 7'b0); failed++;
    end
    @(negedge clk);
    reset = 1'b0; memReady = 1'b0; aluCompTrue = 1'b0;
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b100000) begin
      $display("FAIL first_fetch: got %b required %b", strb, 6'b100000); failed++;
    end
  endtask

  task automatic test_alu_r;
    iword = 32'h3120_0010;   // rd=3 rs1=1 rs2=2 fn=1 op=ALU-R
    cyc(1'b1, 1'b0);
    tests++;
    if ({strb, pcSel} !== {6'b100110, 2'b00}) begin
      $display("FAIL alu_r_fetch: got %b required %b", {strb, pcSel}, {6'b100110, 2'b00}); failed++;
    end
    cyc(1'b1, 1'b0);
    tests++;
    if ({strb, rdIndex0, rdIndex1, wrtIndex, aluFn} !== {6'b0, 4'h1, 4'h2, 4'h3, 5'h01}) begin
      $display("FAIL alu_r_decode: got %h required %h", {strb, rdIndex0, rdIndex1, wrtIndex, aluFn},
               {6'b0, 4'h1, 4'h2, 4'h3, 5'h01}); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if ({strb, aluSrc2Sel} !== 7'b0) begin
      $display("FAIL alu_r_exec: got %b required %b", {strb, aluSrc2Sel}, 7'b0); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if ({strb, regFileWrtSel, wrtIndex} !== {6'b000001, 2'b00, 4'h3}) begin
      $display("FAIL alu_r_wb: got %b required %b", {strb, regFileWrtSel, wrtIndex}, {6'b000001, 2'b00, 4'h3}); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b100000) begin
      $display("FAIL alu_r_refetch: got %b required %b", strb, 6'b100000); failed++;
    end
  endtask

  task automatic test_lw_wait;
    iword = 32'h5612_3439;   // rd=5 rs1=6 fn=3 op=LW
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    tests++;
    if ({strb, aluSrc2Sel} !== {6'b0, 1'b1}) begin
      $display("FAIL lw_exec: got %b required %b", {strb, aluSrc2Sel}, {6'b0, 1'b1}); failed++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0);
      tests++;
      if ({strb, aluFn} !== {6'b110000, 5'h03}) begin
        $display("FAIL lw_mem_wait%0d: got %b required %b", i, {strb, aluFn}, {6'b110000, 5'h03}); failed++;
      end
    end
    cyc(1'b1, 1'b0);
    tests++;
    if ({strb, regFileWrtSel, aluFn, wrtIndex} !== {6'b110001, 2'b01, 5'h03, 4'h5}) begin
      $display("FAIL lw_mem_done: got %b required %b", {strb, regFileWrtSel, aluFn, wrtIndex},
               {6'b110001, 2'b01, 5'h03, 4'h5}); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b100000) begin
      $display("FAIL lw_refetch: got %b required %b", strb, 6'b100000); failed++;
    end
  endtask

  task automatic test_sw;
    iword = 32'h7800_0045;   // src regs 7, 8 fn=4 op=SW
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    tests++;
    if ({rdIndex0, rdIndex1} !== {4'h7, 4'h8}) begin
      $display("FAIL sw_indices: got %h required %h", {rdIndex0, rdIndex1}, {4'h7, 4'h8}); failed++;
    end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    tests++;
    if (strb !== 6'b111000) begin
      $display("FAIL sw_mem: got %b required %b", strb, 6'b111000); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b100000) begin
      $display("FAIL sw_refetch: got %b required %b", strb, 6'b100000); failed++;
    end
  endtask

  task automatic test_branch;
    logic taken;
    iword = 32'h1200_00F6;   // src regs 1, 2 fn=F op=BRANCH
    for (int k = 0; k < 2; k++) begin
      taken = (k == 0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      tests++;
      if ({rdIndex0, rdIndex1, aluFn} !== {4'h1, 4'h2, 5'h1F}) begin
        $display("FAIL br_decode%0d: got %h required %h", k, {rdIndex0, rdIndex1, aluFn}, {4'h1, 4'h2, 5'h1F}); failed++;
      end
      cyc(1'b0, taken);
      tests++;
      if ({strb, pcSel, aluSrc2Sel} !== {4'b0000, taken, 1'b0, 2'b01, 1'b1}) begin
        $display("FAIL br_exec%0d: got %b required %b", k, {strb, pcSel, aluSrc2Sel},
                 {4'b0000, taken, 1'b0, 2'b01, 1'b1}); failed++;
      end
      cyc(1'b0, 1'b0);
      tests++;
      if (strb !== 6'b100000) begin
        $display("FAIL br_refetch%0d: got %b required %b", k, strb, 6'b100000); failed++;
      end
    end
  endtask

  task automatic test_cmp_i;
    iword = 32'h9400_002A;   // rd=9 rs1=4 fn=2 op=CMP-I
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    tests++;
    if ({strb, aluSrc2Sel, aluFn} !== {6'b0, 1'b1, 5'h12}) begin
      $display("FAIL cmpi_exec: got %b required %b", {strb, aluSrc2Sel, aluFn}, {6'b0, 1'b1, 5'h12}); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if ({strb, regFileWrtSel, wrtIndex} !== {6'b000001, 2'b00, 4'h9}) begin
      $display("FAIL cmpi_wb: got %b required %b", {strb, regFileWrtSel, wrtIndex}, {6'b000001, 2'b00, 4'h9}); failed++;
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_jal;
    iword = 32'hA000_000B;   // rd=A op=JAL
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    tests++;
    if ({strb, pcSel, regFileWrtSel} !== {6'b000011, 2'b10, 2'b10}) begin
      $display("FAIL jal_exec: got %b required %b", {strb, pcSel, regFileWrtSel}, {6'b000011, 2'b10, 2'b10}); failed++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b100000) begin
      $display("FAIL jal_refetch: got %b required %b", strb, 6'b100000); failed++;
    end
  endtask

  task automatic test_illegal;
    iword = 32'h0000_00FF;   // op=1111
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    tests++;
    if ({strb, illegal} !== 7'b0) begin
      $display("FAIL ill_decode: got %b required %b", {strb, illegal}, 7'b0); failed++;
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1);
      tests++;
      if ({strb, illegal} !== {6'b0, 1'b1}) begin
        $display("FAIL ill_halt%0d: got %b required %b", i, {strb, illegal}, {6'b0, 1'b1}); failed++;
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({strb, illegal} !== 7'b0) begin
      $display("FAIL ill_reset: got %b required %b", {strb, illegal}, 7'b0); failed++;
    end
    @(negedge clk);
    reset = 1'b0; memReady = 1'b0;
    cyc(1'b0, 1'b0);
    tests++;
    if ({strb, illegal} !== {6'b100000, 1'b0}) begin
      $display("FAIL ill_restart: got %b required %b", {strb, illegal}, {6'b100000, 1'b0}); failed++;
    end
  endtask

  task automatic test_reset_mid_mem;
    iword = 32'h7800_0045;   // SW
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b111000) begin
      $display("FAIL rst_mem_before: got %b required %b", strb, 6'b111000); failed++;
    end
    reset = 1'b1;
    #1;
    tests++;
    if (strb !== 6'b000000) begin
      $display("FAIL rst_mem_async: got %b required %b", strb, 6'b000000); failed++;
    end
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    tests++;
    if (strb !== 6'b100000) begin
      $display("FAIL rst_mem_refetch: got %b required %b", strb, 6'b100000); failed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_r();
    test_lw_wait();
    test_sw();
    test_branch();
    test_cmp_i();
    test_jal();
    test_illegal();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
